// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the fetch / instruction-memory path
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int IMEM_PC_W        = 32;
  localparam int IMEM_INST_W      = 32;
  localparam int IMEM_MAX_LATENCY = 4;

  typedef logic [IMEM_PC_W-1:0]   pc_t;
  typedef logic [IMEM_INST_W-1:0] instruction_t;

  typedef struct packed {
    instruction_t inst;
    pc_t          pc;
    logic         err;
  } imem_rsp_t;

  localparam instruction_t IMEM_ERR_INST = '0;

endpackage
`default_nettype wire

// File: rtl/imem_rsp_fifo.sv
`default_nettype none
// ============================================================================
// imem_rsp_fifo : synchronous response FIFO with flush; head is always presented
// Rev 1.0
// ============================================================================
module imem_rsp_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter type T     = imem_rsp_t
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  T                   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
  endfunction

  assign full   = (r_count == c_CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is reset so the head (and hence the response outputs) read zero out of reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_server.sv
`default_nettype none
// ============================================================================
// imem_server : instruction-memory responder with fixed latency, credit-limited
//               response FIFO, flush and program-load port.
// Optional macro INST_MEM_PARITY_EN adds an even-parity bit per stored word.
// Rev 1.0
// ============================================================================
module imem_server
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int PC_W    = IMEM_PC_W,
  parameter int INST_W  = IMEM_INST_W
) (
  input  logic                     clk,
  input  logic                     arstn,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [PC_W-1:0]          req_pc_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [INST_W-1:0]        rsp_inst_o,
  output logic [PC_W-1:0]          rsp_pc_o,
  output logic                     rsp_err_o,
  input  logic                     flush_i,
  input  logic                     ld_valid_i,
  input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
  input  logic [INST_W-1:0]        ld_data_i
);

  localparam int c_IDX_W      = $clog2(DEPTH);
  localparam int c_FIFO_DEPTH = LATENCY + 1;
  localparam int c_OUT_W      = $clog2(c_FIFO_DEPTH + 1);
`ifdef INST_MEM_PARITY_EN
  localparam int c_WORD_W     = INST_W + 1;
`else
  localparam int c_WORD_W     = INST_W;
`endif

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              err;
  } rsp_t;

  logic [c_WORD_W-1:0]        r_mem [DEPTH];
  logic [c_WORD_W-1:0]        w_word;
  logic [c_WORD_W-1:0]        w_ld_word;
  logic [c_IDX_W-1:0]         w_idx;
  logic                       w_misalign;
  logic                       w_range;
  logic                       w_par_err;
  logic                       w_err;
  logic                       w_accept;
  logic                       w_pop;
  logic                       w_s0_valid;
  rsp_t                       w_s0;
  logic                       w_push_valid;
  rsp_t                       w_push_data;
  rsp_t                       w_head;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [$clog2(c_FIFO_DEPTH+1)-1:0] w_fifo_cnt;
  logic                       w_unused_cnt;
  logic [c_OUT_W-1:0]         r_outstanding;

  // ---------------- memory array (not reset) ----------------
`ifdef INST_MEM_PARITY_EN
  assign w_ld_word = {^ld_data_i, ld_data_i};
  assign w_par_err = ^w_word;
`else
  assign w_ld_word = ld_data_i;
  assign w_par_err = 1'b0;
`endif

  // Read is combinational in the accept cycle, so a same-edge load yields the old word.
  always_ff @(posedge clk) begin
    if (ld_valid_i) r_mem[ld_addr_i] <= w_ld_word;
  end

  assign w_idx      = req_pc_i[2 +: c_IDX_W];
  assign w_word     = r_mem[w_idx];
  assign w_misalign = |req_pc_i[1:0];
  assign w_range    = |req_pc_i[PC_W-1:2+c_IDX_W];
  assign w_err      = w_misalign || w_range || w_par_err;

  // ---------------- request side ----------------
  assign req_ready_o = !flush_i && (r_outstanding < c_OUT_W'(c_FIFO_DEPTH));
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_pop       = rsp_valid_o && rsp_ready_i;

  assign w_s0_valid  = w_accept;
  assign w_s0.pc     = req_pc_i;
  assign w_s0.err    = w_err;
  assign w_s0.inst   = w_err ? INST_W'(IMEM_ERR_INST) : w_word[INST_W-1:0];

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_outstanding <= '0;
    end else if (flush_i) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // ---------------- latency pipe ----------------
  // Stage 0 is the accept cycle; the FIFO write forms the final registered stage.
  generate
    if (LATENCY == 1) begin : g_direct
      assign w_push_valid = w_s0_valid;
      assign w_push_data  = w_s0;
    end else begin : g_pipe
      logic [LATENCY-2:0] r_pv;
      rsp_t               r_pd [LATENCY-1];

      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
          r_pv <= '0;
          for (int k = 0; k < LATENCY - 1; k++) r_pd[k] <= '0;
        end else begin
          r_pv[0] <= w_s0_valid && !flush_i;
          r_pd[0] <= w_s0;
          for (int k = 1; k < LATENCY - 1; k++) begin
            r_pv[k] <= r_pv[k-1] && !flush_i;
            r_pd[k] <= r_pd[k-1];
          end
        end
      end

      assign w_push_valid = r_pv[LATENCY-2];
      assign w_push_data  = r_pd[LATENCY-2];
    end
  endgenerate

  // ---------------- response FIFO ----------------
  imem_rsp_fifo #(
    .DEPTH (c_FIFO_DEPTH),
    .T     (rsp_t)
  ) u_fifo (
    .clk       (clk),
    .arstn     (arstn),
    .push      (w_push_valid && !w_fifo_full),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (flush_i),
    .head      (w_head),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_cnt)
  );

  assign w_unused_cnt = ^w_fifo_cnt;

  assign rsp_valid_o = !w_fifo_empty;
  assign rsp_inst_o  = w_head.inst;
  assign rsp_pc_o    = w_head.pc;
  assign rsp_err_o   = w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_imem_server.sv
`default_nettype none
// Testbench for imem_server: table-driven single requests plus hand-written
// sequences, all checked against a cycle-level scoreboard model.
module tb_imem_server;
  import fetch_pkg::*;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int IDX_W   = 8;

  logic              clk = 1'b0;
  logic              arstn = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [PC_W-1:0]   req_pc_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [INST_W-1:0] rsp_inst_o;
  logic [PC_W-1:0]   rsp_pc_o;
  logic              rsp_err_o;
  logic              flush_i = 1'b0;
  logic              ld_valid_i = 1'b0;
  logic [IDX_W-1:0]  ld_addr_i = '0;
  logic [INST_W-1:0] ld_data_i = '0;

  always #5 clk = ~clk;

  imem_server #(.DEPTH(DEPTH), .LATENCY(LATENCY), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .arstn(arstn),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_pc_i(req_pc_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_inst_o(rsp_inst_o),
    .rsp_pc_o(rsp_pc_o), .rsp_err_o(rsp_err_o), .flush_i(flush_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
  );

  typedef struct {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              err;
    int                avail;
  } exp_t;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              err;
  } vec_t;

  exp_t              sb[$];
  logic [INST_W-1:0] m_mem [DEPTH];
  bit                m_bad [DEPTH];
  int                m_out = 0;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  logic              s_valid, s_ready, s_err;
  logic [INST_W-1:0] s_inst;
  logic [PC_W-1:0]   s_pc;
  vec_t              vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at negedge, compare against the model, advance the model.
  task automatic step();
    exp_t e;
    logic exp_ready, exp_valid, acc, pop;
    int   idx;
    @(negedge clk);
    s_valid = rsp_valid_o; s_ready = req_ready_o;
    s_inst = rsp_inst_o;   s_pc = rsp_pc_o; s_err = rsp_err_o;
    if (!arstn) begin
      check("rst_valid", rsp_valid_o, 0);
      sb.delete();
      m_out = 0;
    end else begin
      exp_ready = !flush_i && (m_out < LATENCY + 1);
      check("req_ready", req_ready_o, exp_ready);
      exp_valid = (sb.size() > 0) && (sb[0].avail <= cyc);
      check("rsp_valid", rsp_valid_o, exp_valid);
      pop = 1'b0;
      if (exp_valid) begin
        check("rsp_inst", rsp_inst_o, sb[0].inst);
        check("rsp_pc", rsp_pc_o, sb[0].pc);
        check("rsp_err", rsp_err_o, sb[0].err);
        if (rsp_ready_i) begin
          pop = 1'b1;
          void'(sb.pop_front());
        end
      end
      acc = req_valid_i && exp_ready;
      if (acc) begin
        idx     = int'(req_pc_i[2 +: IDX_W]);
        e.pc    = req_pc_i;
        e.err   = (req_pc_i[1:0] != 2'b00) || ((req_pc_i >> 2) >= DEPTH) || m_bad[idx];
        e.inst  = e.err ? '0 : m_mem[idx];
        e.avail = cyc + LATENCY;
        sb.push_back(e);
      end
      m_out = m_out + int'(acc) - int'(pop);
      if (flush_i) begin
        sb.delete();
        m_out = 0;
      end
    end
    if (ld_valid_i) begin
      m_mem[ld_addr_i] = ld_data_i;
      m_bad[ld_addr_i] = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input int idx, input logic [INST_W-1:0] data);
    ld_valid_i = 1'b1; ld_addr_i = IDX_W'(idx); ld_data_i = data;
    step();
    ld_valid_i = 1'b0;
  endtask

  task automatic single_req(input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                            input logic err, input string nm);
    bit got = 1'b0;
    req_valid_i = 1'b1; req_pc_i = pc;
    step();
    req_valid_i = 1'b0;
    for (int n = 1; n <= LATENCY + 3 && !got; n++) begin
      step();
      if (s_valid) begin
        got = 1'b1;
        check({nm, "_latency"}, n, LATENCY);
        check({nm, "_inst"}, s_inst, inst);
        check({nm, "_pc"}, s_pc, pc);
        check({nm, "_err"}, s_err, err);
      end
    end
    check({nm, "_seen"}, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nacc, nval;

    vecs[0] = '{32'h0000_000C, 32'h00A0_0093, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'hA500_0000, 1'b0};
    vecs[2] = '{32'h0000_003C, 32'hA500_000F, 1'b0};
    vecs[3] = '{32'h0000_03FC, 32'hA500_00FF, 1'b0};
    vecs[4] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    vecs[5] = '{DEPTH * 4,     32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0024, 32'hA500_0009, 1'b0};

    // Reset state
    step();
    step();
    check("rst_inst", s_inst, 0);
    check("rst_pc", s_pc, 0);
    check("rst_err", s_err, 0);
    arstn = 1'b1;
    step();
    check("rst_ready", s_ready, 1);

    // Program load
    for (int i = 0; i < 16; i++) load(i, 32'hA500_0000 + i);
    load(3, 32'h00A0_0093);
    load(255, 32'hA500_00FF);

    // Table of single requests
    foreach (vecs[i]) single_req(vecs[i].pc, vecs[i].inst, vecs[i].err, $sformatf("vec%0d", i));

    // Back-to-back requests: full throughput, in-order
    nval = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; req_pc_i = PC_W'(4 * i);
      step();
      check("b2b_ready", s_ready, 1);
      nval += int'(s_valid);
    end
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      nval += int'(s_valid);
    end
    check("b2b_count", nval, 4);

    // Backpressure: only LATENCY+1 credits
    rsp_ready_i = 1'b0;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1; req_pc_i = PC_W'(32'h10 + 4 * i);
      step();
      nacc += int'(s_ready);
    end
    check("bp_accepts", nacc, 3);
    check("bp_ready_low", s_ready, 0);
    req_valid_i = 1'b0;
    step();
    rsp_ready_i = 1'b1;
    step();
    step();
    check("bp_ready_back", s_ready, 1);
    for (int i = 0; i < 3; i++) step();

    // Flush with two in flight and a request offered in the flush cycle
    req_valid_i = 1'b1; req_pc_i = 32'h0000_0004;
    step();
    req_pc_i = 32'h0000_0008;
    step();
    flush_i = 1'b1; req_pc_i = 32'h0000_0020;
    step();
    check("flush_no_accept", s_ready, 0);
    flush_i = 1'b0; req_valid_i = 1'b0;
    step();
    check("flush_ready", s_ready, 1);
    nval = int'(s_valid);
    for (int i = 0; i < 3; i++) begin
      step();
      nval += int'(s_valid);
    end
    check("flush_no_rsp", nval, 0);

    // Same-cycle load and read: old word first, new word afterwards
    ld_valid_i = 1'b1; ld_addr_i = 8'd5; ld_data_i = 32'h1111_1111;
    req_valid_i = 1'b1; req_pc_i = 32'h0000_0014;
    step();
    ld_valid_i = 1'b0; req_valid_i = 1'b0;
    nval = 0;
    for (int n = 1; n <= LATENCY + 3; n++) begin
      step();
      if (s_valid && nval == 0) begin
        nval = 1;
        check("rbw_old_inst", s_inst, 32'hA500_0005);
      end
    end
    check("rbw_seen", nval, 1);
    single_req(32'h0000_0014, 32'h1111_1111, 1'b0, "rbw_new");

    // Reset mid-operation: in-flight responses lost, memory retained
    req_valid_i = 1'b1; req_pc_i = 32'h0000_0000;
    step();
    req_pc_i = 32'h0000_0004;
    step();
    req_valid_i = 1'b0;
    arstn = 1'b0;
    step();
    arstn = 1'b1;
    nval = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      nval += int'(s_valid);
    end
    check("rst_mid_no_rsp", nval, 0);
    single_req(32'h0000_000C, 32'h00A0_0093, 1'b0, "rst_mid_mem");

`ifdef INST_MEM_PARITY_EN
    dut.r_mem[2] = dut.r_mem[2] ^ 33'h1;
    m_bad[2] = 1'b1;
    single_req(32'h0000_0008, 32'h0000_0000, 1'b1, "parity");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
